// File: rtl/cbfp_pkg.sv
// Shared CBFP constants and sample types, common to the normaliser and the denormaliser.
package cbfp_pkg;
  localparam int BW_MANT         = 12;
  localparam int BW_FIX          = 25;
  localparam int IDX_W           = 5;
  localparam int TARGET_INT_BITS = 13;
  localparam int BATCH_SIZE      = 16;
  localparam int FRAME_BATCHES   = 32;

  typedef logic signed [BW_MANT-1:0] mant_t;
  typedef logic signed [BW_FIX-1:0]  fix_t;
  typedef logic        [IDX_W-1:0]   idx_t;
endpackage

// File: rtl/cbfp_shift_sat.sv
// Single-sample combinational rescale: left shift or arithmetic right shift, then saturate.
// Right shifts truncate, or round half-up when CBFP_DENORM_ROUND_EN is defined.
module cbfp_shift_sat #(
  parameter int BW_IN           = cbfp_pkg::BW_MANT,
  parameter int BW_OUT          = cbfp_pkg::BW_FIX,
  parameter int TARGET_INT_BITS = cbfp_pkg::TARGET_INT_BITS,
  parameter int D_W             = cbfp_pkg::IDX_W + 2
) (
  input  logic [BW_IN-1:0]  mant,
  input  logic [D_W-1:0]    d,
  input  logic              left,
  output logic [BW_OUT-1:0] res,
  output logic              ovf
);
  localparam int LW = BW_IN + TARGET_INT_BITS;
  // Wide enough to hold either path without wrap before the saturation check.
  localparam int WW = LW + BW_OUT;

  logic signed [LW-1:0]    lsh;
  logic signed [BW_IN:0]   ext;
  logic signed [BW_IN:0]   rsh;
  logic        [D_W-1:0]   rsh_amt;
  logic signed [WW-1:0]    wide;
  logic                    fits;
`ifdef CBFP_DENORM_ROUND_EN
  logic signed [BW_IN:0]   radd;
`endif

  always_comb begin
    rsh_amt = -d;
    lsh     = $signed({{TARGET_INT_BITS{mant[BW_IN-1]}}, mant}) <<< d;
    ext     = $signed({mant[BW_IN-1], mant});
`ifdef CBFP_DENORM_ROUND_EN
    radd = ext + ((BW_IN+1)'(1) << (rsh_amt - D_W'(1)));
    // Beyond BW_IN the magnitude is below a quarter LSB, so half-up always gives zero.
    if (rsh_amt > D_W'(BW_IN)) rsh = '0;
    else                       rsh = radd >>> rsh_amt;
`else
    rsh = ext >>> rsh_amt;
`endif
    if (left) wide = {{(WW-LW){lsh[LW-1]}}, lsh};
    else      wide = {{(WW-BW_IN-1){rsh[BW_IN]}}, rsh};

    fits = (&wide[WW-1:BW_OUT-1]) | ~(|wide[WW-1:BW_OUT-1]);
    ovf  = ~fits;
    if (fits)          res = wide[BW_OUT-1:0];
    else if (wide[WW-1]) res = {1'b1, {(BW_OUT-1){1'b0}}};
    else               res = {1'b0, {(BW_OUT-1){1'b1}}};
  end
endmodule

// File: rtl/cbfp_denorm.sv
// CBFP denormaliser: 16 complex mantissas per cycle rescaled to fixed point, 2-cycle latency.
// Optional macro CBFP_DENORM_ROUND_EN selects half-up rounding on right shifts.
module cbfp_denorm #(
  parameter int BW_IN           = cbfp_pkg::BW_MANT,
  parameter int BW_OUT          = cbfp_pkg::BW_FIX,
  parameter int IDX_W           = cbfp_pkg::IDX_W,
  parameter int TARGET_INT_BITS = cbfp_pkg::TARGET_INT_BITS,
  parameter int BATCH_SIZE      = cbfp_pkg::BATCH_SIZE,
  parameter int FRAME_BATCHES   = cbfp_pkg::FRAME_BATCHES
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [BATCH_SIZE*BW_IN-1:0]  real_in,
  input  logic [BATCH_SIZE*BW_IN-1:0]  imag_in,
  input  logic [BATCH_SIZE*IDX_W-1:0]  index_in,
  output logic [BATCH_SIZE*BW_OUT-1:0] real_out,
  output logic [BATCH_SIZE*BW_OUT-1:0] imag_out,
  output logic                         valid_out,
  output logic                         frame_last_out,
  output logic                         ovf_flag,
  input  logic                         ovf_clr
);
  localparam int D_W   = IDX_W + 2;
  localparam int CNT_W = (FRAME_BATCHES > 1) ? $clog2(FRAME_BATCHES) : 1;

  logic                         valid_s1;
  logic                         last_s1;
  logic [CNT_W-1:0]             batch_cnt;
  logic [BATCH_SIZE*BW_IN-1:0]  real_s1, imag_s1;
  logic [BATCH_SIZE*D_W-1:0]    d_s1, d_nxt;
  logic [BATCH_SIZE-1:0]        left_s1, left_nxt;
  logic [BATCH_SIZE*BW_OUT-1:0] real_res, imag_res;
  logic [2*BATCH_SIZE-1:0]      ovf_lane;

  for (genvar k = 0; k < BATCH_SIZE; k++) begin : g_lane
    // Signed shift distance; negative means a right shift.
    assign d_nxt[k*D_W +: D_W] = D_W'(TARGET_INT_BITS) - {2'b00, index_in[k*IDX_W +: IDX_W]};
    assign left_nxt[k]         = ~d_nxt[k*D_W + D_W - 1];

    cbfp_shift_sat #(
      .BW_IN(BW_IN), .BW_OUT(BW_OUT), .TARGET_INT_BITS(TARGET_INT_BITS), .D_W(D_W)
    ) u_re (
      .mant(real_s1[k*BW_IN +: BW_IN]), .d(d_s1[k*D_W +: D_W]), .left(left_s1[k]),
      .res(real_res[k*BW_OUT +: BW_OUT]), .ovf(ovf_lane[2*k])
    );

    cbfp_shift_sat #(
      .BW_IN(BW_IN), .BW_OUT(BW_OUT), .TARGET_INT_BITS(TARGET_INT_BITS), .D_W(D_W)
    ) u_im (
      .mant(imag_s1[k*BW_IN +: BW_IN]), .d(d_s1[k*D_W +: D_W]), .left(left_s1[k]),
      .res(imag_res[k*BW_OUT +: BW_OUT]), .ovf(ovf_lane[2*k+1])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_s1  <= 1'b0;
      last_s1   <= 1'b0;
      batch_cnt <= '0;
      real_s1   <= '0;
      imag_s1   <= '0;
      d_s1      <= '0;
      left_s1   <= '0;
    end else begin
      valid_s1 <= in_valid;
      if (in_valid) begin
        real_s1   <= real_in;
        imag_s1   <= imag_in;
        d_s1      <= d_nxt;
        left_s1   <= left_nxt;
        last_s1   <= (batch_cnt == CNT_W'(FRAME_BATCHES-1));
        batch_cnt <= (batch_cnt == CNT_W'(FRAME_BATCHES-1)) ? '0 : batch_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out      <= 1'b0;
      frame_last_out <= 1'b0;
      real_out       <= '0;
      imag_out       <= '0;
      ovf_flag       <= 1'b0;
    end else begin
      valid_out      <= valid_s1;
      frame_last_out <= valid_s1 & last_s1;
      if (valid_s1) begin
        real_out <= real_res;
        imag_out <= imag_res;
      end
      // A saturation event outranks a same-cycle clear so it is never lost.
      if (valid_s1 && (|ovf_lane)) ovf_flag <= 1'b1;
      else if (ovf_clr)            ovf_flag <= 1'b0;
    end
  end
endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Inverse of the CBFP stage-1 normaliser, placed at the FFT output after the last butterfly stage.
- Takes 16 complex 12-bit mantissas per cycle, each with its 5-bit block exponent (index), and rescales them to a common 25-bit fixed-point format: value = mant * 2^(TARGET_INT_BITS - index).
- Two-stage pipeline with a frame batch counter that marks frame boundaries, plus a sticky overflow flag.

Parameters:
- BW_IN, 12, mantissa width (signed).
- BW_OUT, 25, output width (signed).
- IDX_W, 5, index width (unsigned).
- TARGET_INT_BITS, 13, exponent reference; index == TARGET_INT_BITS means unity gain.
- BATCH_SIZE, 16, samples per cycle.
- FRAME_BATCHES, 32, batches per frame (512 points / 16).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  batch-valid strobe.
- real_in  input  BW_IN x BATCH_SIZE  signed mantissa, real part.
- imag_in  input  BW_IN x BATCH_SIZE  signed mantissa, imaginary part.
- index_in  input  IDX_W x BATCH_SIZE  per-sample exponent.
- real_out  output  BW_OUT x BATCH_SIZE  denormalised real part.
- imag_out  output  BW_OUT x BATCH_SIZE  denormalised imaginary part.
- valid_out  output  1  output batch valid.
- frame_last_out  output  1  high with the last batch of a frame.
- ovf_flag  output  1  sticky; set when any result saturated.
- ovf_clr  input  1  synchronous clear of ovf_flag.

Behaviour:
- Reset: every output is 0. Pipeline registers are 0. batch_cnt is 0.
- Latency and throughput: fixed 2 cycles from in_valid to valid_out; full throughput of one batch per cycle; no backpressure.
- Stage 1 (S1), registered on in_valid:
  - Capture the mantissas and index.
  - Compute the signed shift d = TARGET_INT_BITS - index (range -18..+13).
  - Compute the per-sample direction bit (left when d >= 0).
- Stage 2 (S2), registered:
  - d >= 0: result = mant <<< d, computed at BW_IN+TARGET_INT_BITS bits, then saturated to BW_OUT.
  - d < 0: result = mant >>> (-d), arithmetic shift (floor).
  - With default parameters the left shift never exceeds 25 bits, so saturation only triggers under non-default parameters. It must still be implemented.
  - Saturation clamps to +2^(BW_OUT-1)-1 or -2^(BW_OUT-1), and sets ovf_flag.
- Real and imaginary parts use the same index per sample. Samples are independent, so indexes may differ within one batch.
- Valid pipeline: valid_s1 <= in_valid; valid_out <= valid_s1. When valid is low, data registers hold their value (no update).
- Batch counter:
  - batch_cnt increments on each S1 valid and wraps from FRAME_BATCHES-1 to 0.
  - frame_last_out is asserted with the output batch whose S1 count was FRAME_BATCHES-1.
  - Gaps in in_valid are allowed; the counter holds during gaps.
- ovf_flag priority: set has priority over ovf_clr in the same cycle. ovf_flag stays high until ovf_clr.
- Reset mid-frame: the counter returns to 0 and the next accepted batch is batch 0.
- Index values above TARGET_INT_BITS+BW_OUT-1 are not expected. They are still computed; the shift saturates to all sign bits.

Optional Feature:
- Macro: CBFP_DENORM_ROUND_EN.
- Defined: the right-shift path rounds half-up. Add 2^(-d-1) before the arithmetic shift, in a width of BW_IN+1 to avoid wrap.
- Undefined: truncate (floor).
- The left-shift path, latency and all flags are identical in both builds.

Decomposition:
- Package cbfp_pkg holds:
  - Constants BW_MANT=12, BW_FIX=25, IDX_W=5, TARGET_INT_BITS=13, BATCH_SIZE=16, FRAME_BATCHES=32.
  - Typedefs mant_t, fix_t, idx_t.
  - This package is shared with the normaliser.
- One sub-module, cbfp_shift_sat: a single-sample combinational shift, round and saturate with an ovf output. It is instantiated 2*BATCH_SIZE times.
- Counter and valid pipeline live in the top module.

Test Plan:
- Unity gain: mant=100, idx=13 on all lanes -> out=100 after 2 cycles, valid_out high exactly one cycle.
- Max left shift: mant=-2048, idx=0 -> out=-16777216; mant=2047, idx=0 -> out=16769024; ovf_flag stays 0.
- Right shift: mant=1000, idx=20 -> out=7 (truncate) or 8 (ROUND_EN); mant=-1000, idx=20 -> -8 in both builds.
- Mixed indexes in one batch (lane k idx=k, mant=1) -> lane k out=2^(13-k) for k<=13, out=0 for k>13 without rounding.
- Frame: 32 consecutive valid batches, then 3 idle cycles, then 32 more -> frame_last_out high on output batches 31 and 63 only; a reset asserted at batch 10 makes the next batch count as 0.
- Non-default BW_OUT=20: mant=2047, idx=0 -> out=524287 and ovf_flag=1; ovf_clr and set in the same cycle -> flag remains 1.
